// File: rtl/mc_controller.sv
// mc_controller: multicycle control unit for the ARM multicycle datapath.
//
// Sequences instruction fetch, decode, memory access, execute, writeback and
// branch through a Moore FSM. All datapath selects and enables are registered.
// Each one is computed from the next state, the next cond_q and the current
// Instr, so the values a state needs are present for that whole state.
//
// Ports:
//   clk         in   1   system clock, rising edge
//   reset       in   1   asynchronous, active-high
//   Instr       in   32  current instruction register contents
//   ALUFlags    in   4   {N,Z,C,V} from the ALU, current cycle
//   PCWrite     out  1   PC register enable
//   MemWrite    out  1   data memory write enable
//   RegWrite    out  1   register file write enable
//   IRWrite     out  1   instruction register enable
//   AdrSrc      out  1   0=PC, 1=Result
//   RegSrc      out  2   [0]: RA1 = R15, [1]: RA2 = Rd (combinational from Op)
//   ALUSrcA     out  2   00=A, 01=PC, 10=ALUOut
//   ALUSrcB     out  2   00=WriteData, 01=ExtImm, 10=constant 4
//   ResultSrc   out  2   00=ALUOut, 01=Data, 10=ALUResult
//   ImmSrc      out  2   Instr[27:26]
//   ALUControl  out  2   00=ADD, 01=SUB, 10=AND, 11=ORR
//   state_o     out  4   current FSM state (debug)
//   instr_count out  32  decoded-instruction counter (only with MC_CTRL_PERF_CNT_EN)
//
// Parameter ILLEGAL_TO_FETCH: 1 = Op 11 returns to FETCH, 0 = Op 11 parks in HALT.
// Optional macro MC_CTRL_PERF_CNT_EN adds the instr_count output and its counter.

module mc_controller #(
  parameter bit ILLEGAL_TO_FETCH = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instr,
  input  logic [3:0]  ALUFlags,
  output logic        PCWrite,
  output logic        MemWrite,
  output logic        RegWrite,
  output logic        IRWrite,
  output logic        AdrSrc,
  output logic [1:0]  RegSrc,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ImmSrc,
  output logic [1:0]  ALUControl,
  output logic [3:0]  state_o
`ifdef MC_CTRL_PERF_CNT_EN
  ,
  output logic [31:0] instr_count
`endif
);

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRd    = 4'd3,
    StMemWb    = 4'd4,
    StMemWr    = 4'd5,
    StExecuteR = 4'd6,
    StExecuteI = 4'd7,
    StAluWb    = 4'd8,
    StBranch   = 4'd9,
    StHalt     = 4'd10
  } state_e;

  typedef struct packed {
    logic       pc_write;
    logic       mem_write;
    logic       reg_write;
    logic       ir_write;
    logic       adr_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic [1:0] alu_control;
  } ctrl_t;

  // Instruction fields
  logic [1:0] op;
  logic       i_bit;
  logic [3:0] cmd;
  logic       s_bit;
  logic [3:0] cond;

  assign op    = Instr[27:26];
  assign i_bit = Instr[25];
  assign cmd   = Instr[24:21];
  assign s_bit = Instr[20];
  assign cond  = Instr[31:28];

  // Rn and the low operand bits belong to the datapath only.
  logic unused_instr;
  assign unused_instr = ^{Instr[19:16], Instr[11:0]};

  // ALU operation selected by cmd; anything unsupported falls back to ADD.
  function automatic logic [1:0] alu_op(input logic [3:0] c);
    logic [1:0] r;
    case (c)
      4'b0010, 4'b1010: r = 2'b01;
      4'b0000:          r = 2'b10;
      4'b1100:          r = 2'b11;
      default:          r = 2'b00;
    endcase
    return r;
  endfunction

  // Commands whose result is written back to Rd (CMP and unsupported are not).
  function automatic logic cmd_writes_rd(input logic [3:0] c);
    return (c == 4'b0100) || (c == 4'b0010) || (c == 4'b0000) || (c == 4'b1100);
  endfunction

  // Commands allowed to update the flag register.
  function automatic logic cmd_sets_flags(input logic [3:0] c);
    return cmd_writes_rd(c) || (c == 4'b1010);
  endfunction

  // Commands that also produce meaningful C and V.
  function automatic logic cmd_arith(input logic [3:0] c);
    return (c == 4'b0100) || (c == 4'b0010) || (c == 4'b1010);
  endfunction

  // ARM condition check against {N,Z,C,V}; 1111 never passes.
  function automatic logic cond_check(input logic [3:0] cc, input logic [3:0] f);
    logic n, z, c, v, r;
    {n, z, c, v} = f;
    case (cc)
      4'b0000: r = z;
      4'b0001: r = !z;
      4'b0010: r = c;
      4'b0011: r = !c;
      4'b0100: r = n;
      4'b0101: r = !n;
      4'b0110: r = v;
      4'b0111: r = !v;
      4'b1000: r = c && !z;
      4'b1001: r = !c || z;
      4'b1010: r = (n == v);
      4'b1011: r = (n != v);
      4'b1100: r = !z && (n == v);
      4'b1101: r = z || (n != v);
      4'b1110: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // Moore output decode for a state. cnd is the cond_q value held in that state.
  function automatic ctrl_t ctrl_for(input state_e st, input logic cnd, input logic [31:0] ins);
    ctrl_t c;
    logic  rd_is_pc;
    c        = '0;
    rd_is_pc = (ins[15:12] == 4'hF);
    case (st)
      StFetch: begin
        c.ir_write   = 1'b1;
        c.alu_src_a  = 2'b01;
        c.alu_src_b  = 2'b10;
        c.result_src = 2'b10;
        c.pc_write   = 1'b1;
      end
      StDecode: begin
        c.alu_src_a  = 2'b01;
        c.alu_src_b  = 2'b10;
        c.result_src = 2'b10;
      end
      StMemAdr: begin
        c.alu_src_b = 2'b01;
      end
      StMemRd: begin
        c.adr_src = 1'b1;
      end
      StMemWb: begin
        c.result_src = 2'b01;
        c.pc_write   = cnd && rd_is_pc;
        c.reg_write  = cnd && !rd_is_pc;
      end
      StMemWr: begin
        c.adr_src   = 1'b1;
        c.mem_write = cnd;
      end
      StExecuteR: begin
        c.alu_control = alu_op(ins[24:21]);
      end
      StExecuteI: begin
        c.alu_src_b   = 2'b01;
        c.alu_control = alu_op(ins[24:21]);
      end
      StAluWb: begin
        c.pc_write  = cnd && cmd_writes_rd(ins[24:21]) && rd_is_pc;
        c.reg_write = cnd && cmd_writes_rd(ins[24:21]) && !rd_is_pc;
      end
      StBranch: begin
        c.alu_src_b  = 2'b01;
        c.result_src = 2'b10;
        c.pc_write   = cnd;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  state_e     state_q, state_d;
  logic       cond_q, cond_d;
  logic [3:0] flags_q, flags_d;
  ctrl_t      ctrl_q;

  always_comb begin
    state_d = state_q;
    cond_d  = cond_q;
    flags_d = flags_q;
    case (state_q)
      StFetch:  state_d = StDecode;
      StDecode: begin
        cond_d = cond_check(cond, flags_q);
        case (op)
          2'b00:   state_d = i_bit ? StExecuteI : StExecuteR;
          2'b01:   state_d = StMemAdr;
          2'b10:   state_d = StBranch;
          default: state_d = ILLEGAL_TO_FETCH ? StFetch : StHalt;
        endcase
      end
      StMemAdr:   state_d = Instr[20] ? StMemRd : StMemWr;
      StMemRd:    state_d = StMemWb;
      StMemWb:    state_d = StFetch;
      StMemWr:    state_d = StFetch;
      StExecuteR,
      StExecuteI: begin
        state_d = StAluWb;
        // Flags land at the edge ending EXECUTE; cond_q for this instruction is
        // already latched, so the update cannot gate its own writeback.
        if (s_bit && cond_q && cmd_sets_flags(cmd)) begin
          flags_d[3:2] = ALUFlags[3:2];
          if (cmd_arith(cmd)) flags_d[1:0] = ALUFlags[1:0];
        end
      end
      StAluWb:  state_d = StFetch;
      StBranch: state_d = StFetch;
      StHalt:   state_d = StHalt;
      default:  state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StFetch;
      cond_q  <= 1'b0;
      flags_q <= 4'b0000;
      ctrl_q  <= ctrl_for(StFetch, 1'b0, 32'h0);
    end else begin
      state_q <= state_d;
      cond_q  <= cond_d;
      flags_q <= flags_d;
      ctrl_q  <= ctrl_for(state_d, cond_d, Instr);
    end
  end

  assign PCWrite    = ctrl_q.pc_write;
  assign MemWrite   = ctrl_q.mem_write;
  assign RegWrite   = ctrl_q.reg_write;
  assign IRWrite    = ctrl_q.ir_write;
  assign AdrSrc     = ctrl_q.adr_src;
  assign ALUSrcA    = ctrl_q.alu_src_a;
  assign ALUSrcB    = ctrl_q.alu_src_b;
  assign ResultSrc  = ctrl_q.result_src;
  assign ALUControl = ctrl_q.alu_control;
  assign state_o    = state_q;

  assign RegSrc = {op == 2'b01, op == 2'b10};
  assign ImmSrc = op;

`ifdef MC_CTRL_PERF_CNT_EN
  // Counts instructions leaving DECODE for real work (wraps naturally).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_count <= 32'd0;
    end else if (state_q == StDecode && state_d != StHalt) begin
      instr_count <= instr_count + 32'd1;
    end
  end
`endif

endmodule
